// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode/direction encodings and parameter check for step counters
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;

  // Width capped at 30 so the (1 << width) range check stays inside a signed int.
  function automatic bit params_legal(input int width, input int step, input int limit);
    return (width >= 1) && (width <= 30) &&
           (step >= 1) && (step <= limit) &&
           (limit <= ((1 << width) - 1));
  endfunction

endpackage

// File: rtl/step_next_calc.sv
// rtl/step_next_calc.sv - combinational next-count and limit-hit for one enabled step
module step_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int STEP  = 2,
  parameter int LIMIT = 6
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             limit_hit
);

  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LIMIT_N = WIDTH'(LIMIT);

  // One extra bit so count + STEP cannot alias when LIMIT is all ones.
  logic [WIDTH:0] sum_x;
  assign sum_x = {1'b0, count} + STEP_X;

  always_comb begin
    next_count = count;
    limit_hit  = 1'b0;
    if (up_dn == DIR_UP) begin
      if (sum_x <= LIMIT_X) begin
        next_count = sum_x[WIDTH-1:0];
      end else begin
        limit_hit  = 1'b1;
        next_count = (sat == MODE_SAT) ? LIMIT_N : '0;
      end
    end else begin
      if ({1'b0, count} >= STEP_X) begin
        next_count = count - STEP_N;
      end else begin
        limit_hit  = 1'b1;
        next_count = (sat == MODE_SAT) ? '0 : LIMIT_N;
      end
    end
  end

endmodule

// File: rtl/step_counter.sv
// rtl/step_counter.sv - parametrised up/down step counter with load, wrap/saturate and limit pulse
module step_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int STEP  = 2,
  parameter int LIMIT = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrapped,
  output logic             at_max,
  output logic             at_min
);

  if (!params_legal(WIDTH, STEP, LIMIT)) begin : g_bad_params
    $fatal(1, "step_counter: illegal WIDTH/STEP/LIMIT combination");
  end

  localparam logic [WIDTH-1:0] LIMIT_N = WIDTH'(LIMIT);

  logic [WIDTH-1:0] next_count;
  logic             limit_hit;
  logic [WIDTH-1:0] load_clamped;

  step_next_calc #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .LIMIT (LIMIT)
  ) u_calc (
    .count      (count),
    .up_dn      (up_dn),
    .sat        (sat),
    .next_count (next_count),
    .limit_hit  (limit_hit)
  );

  assign load_clamped = (load_val > LIMIT_N) ? LIMIT_N : load_val;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (load) begin
      count   <= load_clamped;
      wrapped <= 1'b0;
    end else if (en) begin
      count   <= next_count;
      wrapped <= limit_hit;
    end else begin
      wrapped <= 1'b0;
    end
  end

  assign at_max = (count == LIMIT_N);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_step_counter.sv
// tb/tb_step_counter.sv - directed checks of step_counter at default and 4-bit full-range parameters
module tb_step_counter;

  logic       clk = 1'b0;
  logic       rstn, en, up_dn, sat, load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       wrapped, at_max, at_min;

  logic       rstn2, en2, up_dn2, sat2, load2;
  logic [3:0] load_val2;
  logic [3:0] count2;
  logic       wrapped2, at_max2, at_min2;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  step_counter dut (
    .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .sat(sat),
    .load(load), .load_val(load_val),
    .count(count), .wrapped(wrapped), .at_max(at_max), .at_min(at_min)
  );

  step_counter #(.WIDTH(4), .STEP(3), .LIMIT(15)) dut_wide (
    .clk(clk), .rstn(rstn2), .en(en2), .up_dn(up_dn2), .sat(sat2),
    .load(load2), .load_val(load_val2),
    .count(count2), .wrapped(wrapped2), .at_max(at_max2), .at_min(at_min2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input string tag, input int exp_count, input int exp_wrap);
    tick();
    check({tag, " count"}, 32'(count), 32'(exp_count));
    check({tag, " wrapped"}, 32'(wrapped), 32'(exp_wrap));
  endtask

  task automatic step2(input string tag, input int exp_count, input int exp_wrap);
    tick();
    check({tag, " count"}, 32'(count2), 32'(exp_count));
    check({tag, " wrapped"}, 32'(wrapped2), 32'(exp_wrap));
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; up_dn = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    rstn2 = 1'b0; en2 = 1'b0; up_dn2 = 1'b1; sat2 = 1'b0; load2 = 1'b0; load_val2 = '0;

    tick();
    step1("reset", 0, 0);
    check("reset at_min", 32'(at_min), 1);
    check("reset at_max", 32'(at_max), 0);

    rstn = 1'b1;
    step1("up1", 2, 0);
    step1("up2", 4, 0);
    step1("up3", 6, 0);
    check("up3 at_max", 32'(at_max), 1);
    step1("up4 wrap", 0, 1);
    check("up4 at_min", 32'(at_min), 1);
    step1("up5", 2, 0);

    en = 1'b0; load = 1'b1; load_val = 3'd3;
    step1("load3", 3, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0; sat = 1'b1;
    step1("dnsat1", 1, 0);
    step1("dnsat2", 0, 1);
    step1("dnsat3", 0, 1);

    load = 1'b1; load_val = 3'd7;
    step1("load clamp", 6, 0);
    check("load clamp at_max", 32'(at_max), 1);

    load = 1'b0; sat = 1'b0; up_dn = 1'b0;
    step1("dnwrap1", 4, 0);
    step1("dnwrap2", 2, 0);
    step1("dnwrap3", 0, 0);
    step1("dnwrap4", 6, 1);

    up_dn = 1'b1; sat = 1'b1;
    step1("upsat1", 6, 1);
    step1("upsat2", 6, 1);

    en = 1'b0;
    step1("idle", 6, 0);

    load = 1'b1; load_val = 3'd4;
    step1("load4", 4, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1; sat = 1'b0;
    #2 rstn = 1'b0;
    #1 check("rst between edges", 32'(count), 4);
    step1("mid reset", 0, 0);
    rstn = 1'b1;
    step1("after reset", 2, 0);

    rstn2 = 1'b1; en2 = 1'b1;
    step2("wide1", 3, 0);
    step2("wide2", 6, 0);
    step2("wide3", 9, 0);
    step2("wide4", 12, 0);
    step2("wide5", 15, 0);
    check("wide5 at_max", 32'(at_max2), 1);
    step2("wide6 wrap", 0, 1);
    check("wide6 at_min", 32'(at_min2), 1);
    step2("wide7", 3, 0);

    load2 = 1'b1; load_val2 = 4'd14;
    step2("wide load14", 14, 0);
    load2 = 1'b0; sat2 = 1'b1;
    step2("wide sat", 15, 1);
    up_dn2 = 1'b0; sat2 = 1'b0;
    step2("wide dn", 12, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
